// File: rtl/ascon_sigma_seq.sv
// ascon_sigma_seq
// Sequences a full Ascon state through one shared 32-bit sigma datapath.
// Each 64-bit lane is presented as two halves (low half first, then high half).
// The lane index goes out as the immediate that selects the rotation pair.
// The returned 32-bit results are gathered into a destination state.
// That state is handed back through a valid/ready handshake.
module ascon_sigma_seq #(
   parameter int LANES     = 5,
   parameter bit ZERO_IDLE = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [64*LANES-1:0]   in_state,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [64*LANES-1:0]   out_state,
   output logic                  busy,
   input  logic                  flush,
   output logic [31:0]           dp_rs1,
   output logic [31:0]           dp_rs2,
   output logic [4:0]            dp_imm,
   output logic                  dp_op_lo,
   output logic                  dp_op_hi,
   input  logic [31:0]           dp_rd
);

   localparam int            STEPS = 2 * LANES;
   localparam int            CW    = $clog2(STEPS);
   localparam logic [CW-1:0] LAST  = CW'(STEPS - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [64*LANES-1:0]  src_q, src_d;
   logic [64*LANES-1:0]  dst_q, dst_d;

   logic [31:0]          hold_rs1_q, hold_rs2_q;
   logic [4:0]           hold_imm_q;
   logic                 hold_lo_q, hold_hi_q;

   logic [CW-1:0]        lane_w;
   logic                 half_w;
   logic [31:0]          run_rs1, run_rs2;
   logic                 accept;

   // The step counter encodes both the lane (upper bits) and which half is on the bus (bit 0).
   // The source state is never modified while running, so both halves of a lane read the original operand.
   always_comb begin
      lane_w  = cnt_q >> 1;
      half_w  = cnt_q[0];
      run_rs1 = src_q[64*lane_w +: 32];
      run_rs2 = src_q[64*lane_w + 32 +: 32];
   end

   // The handshake outputs decode directly from the state register.
   // in_ready is also masked by reset so an upstream stage never sees a stale accept while the block is held in reset.
   always_comb begin
      in_ready  = (state_q == IDLE) && !rst;
      out_valid = (state_q == DONE);
      busy      = (state_q != IDLE);
      out_state = dst_q;
      accept    = in_valid && in_ready && !flush;
   end

   // Datapath operands are live only while running.
   // Outside RUN they are either zeroed, or they hold the last issued values so the shared datapath sees no toggling.
   always_comb begin
      dp_rs1   = 32'd0;
      dp_rs2   = 32'd0;
      dp_imm   = 5'd0;
      dp_op_lo = 1'b0;
      dp_op_hi = 1'b0;
      if (state_q == RUN) begin
         dp_rs1   = run_rs1;
         dp_rs2   = run_rs2;
         dp_imm   = 5'(lane_w);
         dp_op_lo = ~half_w;
         dp_op_hi = half_w;
      end else if (!ZERO_IDLE) begin
         dp_rs1   = hold_rs1_q;
         dp_rs2   = hold_rs2_q;
         dp_imm   = hold_imm_q;
         dp_op_lo = hold_lo_q;
         dp_op_hi = hold_hi_q;
      end
   end

   // Next-state logic for the sequencer.
   // Flush beats every other transition and drops the job.
   // While running, each cycle stores the datapath result into its slot in the destination state.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      src_d   = src_q;
      dst_d   = dst_q;
      if (flush) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (accept) begin
                  state_d = RUN;
                  src_d   = in_state;
                  dst_d   = '0;
                  cnt_d   = '0;
               end
            end
            RUN: begin
               dst_d[64*lane_w + 32*half_w +: 32] = dp_rd;
               if (cnt_q == LAST) begin
                  state_d = DONE;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_d = IDLE;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // State, counter and the two state buffers.
   // Reset is asynchronous so that an abort mid-job takes effect immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         src_q   <= '0;
         dst_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
      end
   end

   // Remember the last operands issued during RUN.
   // These are the values the datapath bus holds when idle zeroing is disabled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_rs1_q <= 32'd0;
         hold_rs2_q <= 32'd0;
         hold_imm_q <= 5'd0;
         hold_lo_q  <= 1'b0;
         hold_hi_q  <= 1'b0;
      end else if (state_q == RUN) begin
         hold_rs1_q <= run_rs1;
         hold_rs2_q <= run_rs2;
         hold_imm_q <= 5'(lane_w);
         hold_lo_q  <= ~half_w;
         hold_hi_q  <= half_w;
      end
   end

endmodule

// File: tb/tb_ascon_sigma_seq.sv
// tb_ascon_sigma_seq
// Drives the sigma sequencer with directed and random Ascon states.
// A bit-level sigma datapath model is attached to the dp_* bus.
// Every result is compared against a lane-wise rotate-and-xor reference of the Ascon linear layer.
module tb_ascon_sigma_seq;

   localparam int LANES = 5;
   localparam int W     = 64 * LANES;

   logic           clk;
   logic           rst;
   logic           in_valid;
   logic           in_ready;
   logic [W-1:0]   in_state;
   logic           out_valid;
   logic           out_ready;
   logic [W-1:0]   out_state;
   logic           busy;
   logic           flush;
   logic [31:0]    dp_rs1;
   logic [31:0]    dp_rs2;
   logic [4:0]     dp_imm;
   logic           dp_op_lo;
   logic           dp_op_hi;
   logic [31:0]    dp_rd;

   int             checks;
   int             errors;

   logic [4:0]     immAt [0:9];
   logic           loAt  [0:9];
   logic           hiAt  [0:9];

   ascon_sigma_seq #(.LANES(LANES), .ZERO_IDLE(1'b1)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_state  (in_state),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_state (out_state),
      .busy      (busy),
      .flush     (flush),
      .dp_rs1    (dp_rs1),
      .dp_rs2    (dp_rs2),
      .dp_imm    (dp_imm),
      .dp_op_lo  (dp_op_lo),
      .dp_op_hi  (dp_op_hi),
      .dp_rd     (dp_rd)
   );

   // Free-running 10-time-unit clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Per-bit sigma datapath: output bit i mixes input bits i, i+a and i+b (mod 64)
   function automatic logic [63:0] dpSigma(input logic [63:0] x, input logic [4:0] imm);
      int a;
      int b;
      logic [63:0] r;
      case (imm)
         5'd0:    begin a = 19; b = 28; end
         5'd1:    begin a = 61; b = 39; end
         5'd2:    begin a = 1;  b = 6;  end
         5'd3:    begin a = 10; b = 17; end
         default: begin a = 7;  b = 41; end
      endcase
      for (int i = 0; i < 64; i++) begin
         r[i] = x[i] ^ x[(i + a) % 64] ^ x[(i + b) % 64];
      end
      return r;
   endfunction

   // The shared datapath answers combinationally with the selected half
   always_comb begin
      logic [63:0] full;
      full  = dpSigma({dp_rs2, dp_rs1}, dp_imm);
      dp_rd = dp_op_hi ? full[63:32] : full[31:0];
   end

   function automatic logic [63:0] ror(input logic [63:0] x, input int n);
      return (x >> n) | (x << (64 - n));
   endfunction

   // Reference Ascon linear layer on a whole lane
   function automatic logic [63:0] refLane(input logic [63:0] x, input int lane);
      case (lane)
         0:       return x ^ ror(x, 19) ^ ror(x, 28);
         1:       return x ^ ror(x, 61) ^ ror(x, 39);
         2:       return x ^ ror(x, 1)  ^ ror(x, 6);
         3:       return x ^ ror(x, 10) ^ ror(x, 17);
         default: return x ^ ror(x, 7)  ^ ror(x, 41);
      endcase
   endfunction

   function automatic logic [W-1:0] refState(input logic [W-1:0] s);
      logic [W-1:0] r;
      for (int l = 0; l < LANES; l++) begin
         r[64*l +: 64] = refLane(s[64*l +: 64], l);
      end
      return r;
   endfunction

   function automatic logic [W-1:0] randState();
      logic [W-1:0] r;
      for (int i = 0; i < W / 32; i++) begin
         r[32*i +: 32] = $urandom;
      end
      return r;
   endfunction

   // One comparison: count it, and on mismatch count and report it
   task automatic checkOutput(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer a state for one cycle; returns sampled just after the accepting edge (step 0)
   task automatic applyStimulus(input logic [W-1:0] st);
      checkOutput("ready_before_accept", W'(in_ready), W'(1));
      in_valid = 1'b1;
      in_state = st;
      tick();
      in_valid = 1'b0;
      in_state = randState();
   endtask

   // Run one job with out_ready high; record per-step datapath controls, latency and in_ready-low cycles
   task automatic runJob(input logic [W-1:0] st, output logic [W-1:0] res, output int lat, output int low);
      lat = -1;
      low = 0;
      res = '0;
      applyStimulus(st);
      for (int k = 0; k < 40; k++) begin
         if (k < 10) begin
            immAt[k] = dp_imm;
            loAt[k]  = dp_op_lo;
            hiAt[k]  = dp_op_hi;
         end
         if (out_valid && lat < 0) begin
            lat = k;
            res = out_state;
         end
         if (in_ready) break;
         low++;
         tick();
      end
   endtask

   initial begin
      logic [W-1:0] st;
      logic [W-1:0] res;
      logic [W-1:0] held;
      int lat;
      int low;
      bit sawValid;
      bit stable;

      checks    = 0;
      errors    = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_state  = '0;
      out_ready = 1'b1;
      flush     = 1'b0;

      // Reset values
      #1;
      checkOutput("rst_in_ready", W'(in_ready), W'(0));
      checkOutput("rst_out_valid", W'(out_valid), W'(0));
      checkOutput("rst_busy", W'(busy), W'(0));
      checkOutput("rst_dp_bus", W'({dp_rs1, dp_rs2, dp_imm, dp_op_lo, dp_op_hi}), W'(0));
      checkOutput("rst_out_state", out_state, '0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      checkOutput("post_rst_in_ready", W'(in_ready), W'(1));
      tick();

      // Reset while running at step 4
      applyStimulus(randState());
      repeat (4) tick();
      checkOutput("cnt4_imm", W'(dp_imm), W'(2));
      checkOutput("cnt4_lo", W'(dp_op_lo), W'(1));
      rst = 1'b1;
      #1;
      checkOutput("midrun_rst_out_valid", W'(out_valid), W'(0));
      checkOutput("midrun_rst_busy", W'(busy), W'(0));
      checkOutput("midrun_rst_lohi", W'({dp_op_lo, dp_op_hi}), W'(0));
      tick();
      rst = 1'b0;
      #1;
      checkOutput("midrun_release_ready", W'(in_ready), W'(1));
      tick();

      // All-zero state: latency and in_ready-low window
      runJob('0, res, lat, low);
      checkOutput("zero_latency", W'(lat), W'(10));
      checkOutput("zero_result", res, '0);
      checkOutput("zero_ready_low", W'(low), W'(11));

      // Single bit in lane 0
      st = '0;
      st[0] = 1'b1;
      runJob(st, res, lat, low);
      checkOutput("lane0_result", res, W'(64'h0000201000000001));
      checkOutput("lane0_cnt0_lo_imm", W'({loAt[0], immAt[0]}), W'({1'b1, 5'd0}));
      checkOutput("lane0_cnt1_hi", W'({hiAt[1], loAt[1]}), W'({1'b1, 1'b0}));

      // Single bit in lane 2
      st = '0;
      st[128] = 1'b1;
      held = '0;
      held[128 +: 64] = 64'h8400000000000001;
      runJob(st, res, lat, low);
      checkOutput("lane2_result", res, held);
      checkOutput("lane2_imm_cnt4_5", W'({immAt[4], immAt[5]}), W'({5'd2, 5'd2}));

      // Random jobs against the reference
      for (int j = 0; j < 8; j++) begin
         st = randState();
         runJob(st, res, lat, low);
         checkOutput($sformatf("rand%0d_result", j), res, refState(st));
         checkOutput($sformatf("rand%0d_latency", j), W'(lat), W'(10));
      end

      // Back-pressure in DONE
      out_ready = 1'b0;
      st = randState();
      applyStimulus(st);
      for (int k = 0; k < 40; k++) begin
         if (out_valid) break;
         tick();
      end
      checkOutput("bp_valid", W'(out_valid), W'(1));
      held = out_state;
      checkOutput("bp_result", held, refState(st));
      stable = 1'b1;
      in_valid = 1'b1;
      for (int k = 0; k < 7; k++) begin
         in_state = randState();
         tick();
         if (!out_valid || out_state !== held || in_ready) stable = 1'b0;
      end
      in_valid = 1'b0;
      checkOutput("bp_stable", W'(stable), W'(1));
      out_ready = 1'b1;
      tick();
      checkOutput("bp_drain_ready", W'(in_ready), W'(1));
      checkOutput("bp_drain_valid", W'(out_valid), W'(0));
      st = randState();
      runJob(st, res, lat, low);
      checkOutput("bp_next_result", res, refState(st));

      // Flush at step 6
      applyStimulus(randState());
      repeat (6) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checkOutput("flush_ready", W'(in_ready), W'(1));
      checkOutput("flush_busy", W'(busy), W'(0));
      sawValid = 1'b0;
      for (int k = 0; k < 12; k++) begin
         if (out_valid) sawValid = 1'b1;
         tick();
      end
      checkOutput("flush_no_valid", W'(sawValid), W'(0));
      st = randState();
      runJob(st, res, lat, low);
      checkOutput("flush_next_result", res, refState(st));

      // Flush in IDLE blocks acceptance
      in_valid = 1'b1;
      in_state = randState();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      checkOutput("idle_flush_blocks", W'({in_ready, busy}), W'({1'b1, 1'b0}));

      // Flush in DONE
      out_ready = 1'b0;
      applyStimulus(randState());
      for (int k = 0; k < 40; k++) begin
         if (out_valid) break;
         tick();
      end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      out_ready = 1'b1;
      checkOutput("done_flush", W'({out_valid, in_ready}), W'({1'b0, 1'b1}));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
